draw_vector_fx: RTL and testbench
=================================

Name: draw_vector_fx

Overview:
Parametrised successor to the single-arrow block drawer. Rasterises one fixed-point vector into the framebuffer write port at one pixel per clock: a line, an erase line, or a solid block fill. Adds mode select, multi-bit colour, screen clipping, length capping and a busy/done handshake. Sits between the simulation-to-display scheduler and the framebuffer BRAM write port.

Parameters:
DRAW_WIDTH, 320, framebuffer width in pixels
DRAW_HEIGHT, 240, framebuffer height in pixels
DRAW_ADDRW, $clog2(DRAW_WIDTH*DRAW_HEIGHT), write address width
DRAW_DATAW, 4, pixel data width
FRAC_BITS, 16, fractional bits of all fixed-point inputs
MAX_LEN, 64, cap on line step count N
BLOCK_SIZE, 8, edge length in pixels of the FILL square
BG_COLOR, 0, pixel value written by ERASE

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; accepted only when busy=0
mode  in  2  0=LINE, 1=ERASE, 2=FILL, 3=reserved (treated as LINE)
color  in  DRAW_DATAW  pixel value for LINE and FILL
block_x  in  32  origin x, signed Q16.16
block_y  in  32  origin y, signed Q16.16
xn  in  32  step x, signed Q16.16
yn  in  32  step y, signed Q16.16
mag  in  32  length, unsigned Q16.16
draw_addr_write  out  DRAW_ADDRW  framebuffer write address
draw_data_in  out  DRAW_DATAW  framebuffer write data
draw_we  out  1  write enable
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-low, on rising clk. All outputs go to 0 and the FSM goes to IDLE. A reset mid-operation aborts it: no further writes and no done pulse.
- FSM states: IDLE, LINE, FILL, DONE.
- IDLE: on start=1, latch all inputs and set busy=1.
  - mode 2 goes to FILL.
  - Any other mode goes to LINE.
- Accept timing: start accepted at edge t; point k is presented (registered outputs) in cycle t+1+k.
- Start while busy=1 is ignored. Inputs are not re-latched.
- LINE / ERASE:
  - N = min(mag >> FRAC_BITS, MAX_LEN). Emit N+1 points, k = 0..N.
  - Point k: p = origin + k*(xn,yn), computed by 32-bit wrapping accumulator add. No multiplier on the step path.
  - Pixel coordinates use an arithmetic shift (floor): px = p_x >>> FRAC_BITS, same for py.
  - draw_data_in = color for LINE, BG_COLOR for ERASE.
- FILL:
  - Corner (cx, cy) = integer parts of the origin.
  - Emit BLOCK_SIZE² points in row-major order, x fastest.
  - Data = color. xn, yn and mag are ignored.
- Address and clipping, every point:
  - draw_addr_write = py*DRAW_WIDTH + px.
  - If px<0, px≥DRAW_WIDTH, py<0 or py≥DRAW_HEIGHT: draw_we=0 and the address is don't-care, but the cycle is still consumed. Timing does not depend on clipping.
- Completion:
  - After the last point, go to DONE for one cycle: done=1, busy=0, draw_we=0.
  - A start in the DONE cycle is accepted.
  - Then return to IDLE.
- mag < 1.0 gives N=0: one pixel at the origin, and done at t+2.
- Accumulator overflow wraps silently. Any resulting off-screen points are clipped.
- draw_we is 0 in IDLE and DONE.

Decomposition:
- Package draw_pkg holds:
  - draw_mode_t enum (LINE, ERASE, FILL);
  - draw_state_t enum;
  - localparam FRAC_BITS_DEFAULT = 16;
  - a fixed-point floor helper function.
- Sub-module draw_pix_addr: combinational. Takes signed px, py and returns the address plus an in_bounds flag. Shared by both the LINE and FILL paths.

Test Plan:
- LINE, origin (40,40), xn=0, yn=1.0 (0x00010000), mag=10.0, colour 5, start at t:
  - 11 writes, addresses 12840, 13160, …, 16040, data 5, in cycles t+1..t+11;
  - done=1 at t+12;
  - busy high t+1..t+11.
- Clip right edge, origin (318,10), xn=1.0, mag=5.0:
  - 6 point cycles; draw_we=1 only for addresses 3518 and 3519;
  - done at t+7.
- Negative step and floor, origin (1.0,0), xn=0xFFFF0000, mag=3.0:
  - writes at addresses 1 and 0;
  - points −1 and −2 suppressed;
  - origin x=−0.5 (0xFFFF8000) → point at px=−1, clipped.
- FILL, origin (16,8), BLOCK_SIZE=8, colour 3:
  - 64 consecutive writes; first address 2576, last 4823, row stride 320;
  - done at t+65;
  - repeat with mode=ERASE as a LINE: data=BG_COLOR.
- Cap, and start while busy:
  - mag=100.0 → exactly MAX_LEN+1=65 writes;
  - a second start pulse at t+5 is ignored; a start during the DONE cycle is accepted.
- Reset mid-operation:
  - rst_n=0 in cycle t+5 of a LINE → draw_we=0, busy=0, done=0 from the next edge;
  - no done pulse ever follows.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and fixed-point helpers for the vector rasteriser.
package draw_pkg;

   typedef enum logic [1:0] {
      MODE_LINE  = 2'd0,
      MODE_ERASE = 2'd1,
      MODE_FILL  = 2'd2
   } draw_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LINE = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } draw_state_t;

   localparam int unsigned FRAC_BITS_DEFAULT = 16;

   // Integer part of a signed fixed-point value, rounded toward minus infinity.
   function automatic logic signed [31:0] fx_floor(input logic signed [31:0] v,
                                                    input int unsigned frac);
      return v >>> frac;
   endfunction

endpackage

// File: rtl/draw_pix_addr.sv
// Pixel coordinate to framebuffer address, with on-screen test.
module draw_pix_addr #(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240,
   parameter int unsigned ADDRW  = 17
) (
   input  logic signed [31:0] px,
   input  logic signed [31:0] py,
   output logic [ADDRW-1:0]   addr_c,
   output logic               in_bounds_c
);

   // Negative coordinates have the sign bit set, so the unsigned compares reject them too.
   always_comb begin
      addr_c      = ADDRW'($unsigned(py) * 32'(WIDTH) + $unsigned(px));
      in_bounds_c = !px[31] && !py[31] &&
                    ($unsigned(px) < 32'(WIDTH)) && ($unsigned(py) < 32'(HEIGHT));
   end

endmodule

// File: rtl/draw_vector_fx.sv
// Rasterises one fixed-point line, erase line or solid block, one pixel per clock.
module draw_vector_fx
   import draw_pkg::*;
#(
   parameter int unsigned DRAW_WIDTH  = 320,
   parameter int unsigned DRAW_HEIGHT = 240,
   parameter int unsigned DRAW_ADDRW  = $clog2(DRAW_WIDTH * DRAW_HEIGHT),
   parameter int unsigned DRAW_DATAW  = 4,
   parameter int unsigned FRAC_BITS   = FRAC_BITS_DEFAULT,
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned BLOCK_SIZE  = 8,
   parameter int unsigned BG_COLOR    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [DRAW_DATAW-1:0] color,
   input  logic [31:0]           block_x,
   input  logic [31:0]           block_y,
   input  logic [31:0]           xn,
   input  logic [31:0]           yn,
   input  logic [31:0]           mag,
   output logic [DRAW_ADDRW-1:0] draw_addr_write,
   output logic [DRAW_DATAW-1:0] draw_data_in,
   output logic                  draw_we,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned FILL_LAST = BLOCK_SIZE * BLOCK_SIZE - 1;

   draw_state_t        state_q;
   logic signed [31:0] acc_x_q, acc_y_q;
   logic signed [31:0] step_x_q, step_y_q;
   logic signed [31:0] corner_x_q, corner_y_q;
   logic [31:0]        fill_x_q, fill_y_q;
   logic [31:0]        rem_q;

   logic signed [31:0] acc_nx_c, acc_ny_c;
   logic [31:0]        fill_nx_c, fill_ny_c;
   logic signed [31:0] px_c, py_c;
   logic [31:0]        mag_int_c, line_n_c;
   logic [DRAW_ADDRW-1:0] pt_addr_c;
   logic               pt_in_c;

   // Next point: the incoming origin when idle, otherwise one step past the presented point.
   always_comb begin
      acc_nx_c  = acc_x_q + step_x_q;
      acc_ny_c  = acc_y_q + step_y_q;
      fill_nx_c = fill_x_q + 32'd1;
      fill_ny_c = fill_y_q;
      if (fill_x_q == 32'(BLOCK_SIZE - 1)) begin
         fill_nx_c = 32'd0;
         fill_ny_c = fill_y_q + 32'd1;
      end
      mag_int_c = mag >> FRAC_BITS;
      line_n_c  = (mag_int_c > 32'(MAX_LEN)) ? 32'(MAX_LEN) : mag_int_c;
      case (state_q)
         ST_LINE: begin
            px_c = fx_floor(acc_nx_c, FRAC_BITS);
            py_c = fx_floor(acc_ny_c, FRAC_BITS);
         end
         ST_FILL: begin
            px_c = corner_x_q + $signed(fill_nx_c);
            py_c = corner_y_q + $signed(fill_ny_c);
         end
         default: begin
            px_c = fx_floor($signed(block_x), FRAC_BITS);
            py_c = fx_floor($signed(block_y), FRAC_BITS);
         end
      endcase
   end

   draw_pix_addr #(
      .WIDTH  (DRAW_WIDTH),
      .HEIGHT (DRAW_HEIGHT),
      .ADDRW  (DRAW_ADDRW)
   ) u_pix_addr (
      .px          (px_c),
      .py          (py_c),
      .addr_c      (pt_addr_c),
      .in_bounds_c (pt_in_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         draw_addr_write <= '0;
         draw_data_in    <= '0;
         draw_we         <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         acc_x_q         <= '0;
         acc_y_q         <= '0;
         step_x_q        <= '0;
         step_y_q        <= '0;
         corner_x_q      <= '0;
         corner_y_q      <= '0;
         fill_x_q        <= '0;
         fill_y_q        <= '0;
         rem_q           <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done    <= 1'b0;
               draw_we <= 1'b0;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
               if (start) begin
                  // Point 0 is presented straight from the incoming origin.
                  busy            <= 1'b1;
                  draw_we         <= pt_in_c;
                  draw_addr_write <= pt_addr_c;
                  draw_data_in    <= (mode == MODE_ERASE) ? DRAW_DATAW'(BG_COLOR) : color;
                  acc_x_q         <= $signed(block_x);
                  acc_y_q         <= $signed(block_y);
                  step_x_q        <= $signed(xn);
                  step_y_q        <= $signed(yn);
                  corner_x_q      <= fx_floor($signed(block_x), FRAC_BITS);
                  corner_y_q      <= fx_floor($signed(block_y), FRAC_BITS);
                  fill_x_q        <= '0;
                  fill_y_q        <= '0;
                  if (mode == MODE_FILL) begin
                     state_q <= ST_FILL;
                     rem_q   <= 32'(FILL_LAST);
                  end else begin
                     state_q <= ST_LINE;
                     rem_q   <= line_n_c;
                  end
               end
            end
            ST_LINE, ST_FILL: begin
               if (rem_q == 32'd0) begin
                  state_q <= ST_DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  draw_we <= 1'b0;
               end else begin
                  rem_q           <= rem_q - 32'd1;
                  draw_we         <= pt_in_c;
                  draw_addr_write <= pt_addr_c;
                  acc_x_q         <= acc_nx_c;
                  acc_y_q         <= acc_ny_c;
                  fill_x_q        <= fill_nx_c;
                  fill_y_q        <= fill_ny_c;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_vector_fx.sv
// Directed scoreboard bench for draw_vector_fx: expected writes/done pulses queued at drive time.
module tb_draw_vector_fx;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  mode;
   logic [3:0]  color;
   logic [31:0] block_x, block_y, xn, yn, mag;
   logic [16:0] draw_addr_write;
   logic [3:0]  draw_data_in;
   logic        draw_we, busy, done;

   draw_vector_fx dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .mode            (mode),
      .color           (color),
      .block_x         (block_x),
      .block_y         (block_y),
      .xn              (xn),
      .yn              (yn),
      .mag             (mag),
      .draw_addr_write (draw_addr_write),
      .draw_data_in    (draw_data_in),
      .draw_we         (draw_we),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errs = 0;
   int chks = 0;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   int  done_q[$];
   wr_t mon_e;
   int  mon_d;

   task automatic check(input string tag, input int obs, input int exp);
      chks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: point k = origin + k*step, floored, clipped to 320x240.
   task automatic push_line(input int t, input int bx, input int by, input int sx,
                            input int sy, input logic [31:0] mg, input int data);
      int n, px, py;
      n = int'(mg >> 16);
      if (n > 64) n = 64;
      for (int k = 0; k <= n; k++) begin
         px = (bx + k * sx) >>> 16;
         py = (by + k * sy) >>> 16;
         if (px >= 0 && px < 320 && py >= 0 && py < 240)
            exp_q.push_back('{t + 1 + k, py * 320 + px, data});
      end
      done_q.push_back(t + n + 2);
   endtask

   task automatic push_fill(input int t, input int cx, input int cy, input int data);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            exp_q.push_back('{t + 1 + r * 8 + c, (cy + r) * 320 + cx + c, data});
      done_q.push_back(t + 65);
   endtask

   task automatic start_op(input logic [1:0] m, input logic [3:0] c, input logic [31:0] bx,
                           input logic [31:0] by, input logic [31:0] sx, input logic [31:0] sy,
                           input logic [31:0] mg);
      mode = m; color = c; block_x = bx; block_y = by; xn = sx; yn = sy; mag = mg;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Output monitor: every write and every done pulse must match the queue head.
   always @(negedge clk) begin
      if (draw_we === 1'b1) begin
         check("wr_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_cycle", cyc, mon_e.cyc);
            check("wr_addr", int'(draw_addr_write), mon_e.addr);
            check("wr_data", int'(draw_data_in), mon_e.data);
         end
      end
      if (done === 1'b1) begin
         check("done_expected", int'(done_q.size() != 0), 1);
         if (done_q.size() != 0) begin
            mon_d = done_q.pop_front();
            check("done_cycle", cyc, mon_d);
            check("done_busy_low", int'(busy), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   int t, t2;

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = '0; color = '0;
      block_x = '0; block_y = '0; xn = '0; yn = '0; mag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", int'(draw_we), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(draw_addr_write), 0);
      check("rst_data", int'(draw_data_in), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vertical line down from (40,40), 11 points.
      t = cyc;
      push_line(t, 32'h0028_0000, 32'h0028_0000, 0, 32'h0001_0000, 32'h000A_0000, 5);
      start_op(2'd0, 4'd5, 32'h0028_0000, 32'h0028_0000, 32'h0, 32'h0001_0000, 32'h000A_0000);
      check("line_busy_first", int'(busy), 1);
      wait_until(t + 11);
      check("line_busy_last", int'(busy), 1);
      check("line_we_last", int'(draw_we), 1);
      wait_until(t + 12);
      check("line_done", int'(done), 1);
      check("line_done_we", int'(draw_we), 0);
      wait_until(t + 13);
      check("line_idle_busy", int'(busy), 0);

      // Right-edge clip from (318,10).
      t = cyc;
      push_line(t, 32'h013E_0000, 32'h000A_0000, 32'h0001_0000, 0, 32'h0005_0000, 2);
      start_op(2'd0, 4'd2, 32'h013E_0000, 32'h000A_0000, 32'h0001_0000, 32'h0, 32'h0005_0000);
      wait_until(t + 7);
      check("clip_done", int'(done), 1);
      wait_until(t + 8);

      // Negative step crossing x=0.
      t = cyc;
      push_line(t, 32'h0001_0000, 0, 32'hFFFF_0000, 0, 32'h0003_0000, 4);
      start_op(2'd0, 4'd4, 32'h0001_0000, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0003_0000);
      wait_until(t + 6);

      // Origin x = -0.5 floors to -1: single clipped point, done at t+2.
      t = cyc;
      push_line(t, 32'hFFFF_8000, 0, 0, 0, 32'h0000_8000, 6);
      start_op(2'd0, 4'd6, 32'hFFFF_8000, 32'h0, 32'h0, 32'h0, 32'h0000_8000);
      check("neg_half_we", int'(draw_we), 0);
      wait_until(t + 2);
      check("neg_half_done", int'(done), 1);
      wait_until(t + 3);

      // Block fill at (16.5, 8); step and length inputs carry junk.
      t = cyc;
      push_fill(t, 16, 8, 3);
      start_op(2'd2, 4'd3, 32'h0010_8000, 32'h0008_0000, 32'h1234_5678, 32'h8765_4321, 32'h7FFF_0000);
      wait_until(t + 65);
      check("fill_done", int'(done), 1);
      wait_until(t + 66);

      // Erase line with half-pixel step.
      t = cyc;
      push_line(t, 32'h0064_0000, 32'h00C8_0000, 32'h0000_8000, 0, 32'h0004_0000, 0);
      start_op(2'd1, 4'd7, 32'h0064_0000, 32'h00C8_0000, 32'h0000_8000, 32'h0, 32'h0004_0000);
      wait_until(t + 7);

      // Length cap, ignored start while busy, start accepted in DONE cycle.
      t = cyc;
      push_line(t, 0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0064_0000, 10);
      start_op(2'd0, 4'd10, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0064_0000);
      wait_until(t + 5);
      start_op(2'd2, 4'd1, 32'h0050_0000, 32'h0050_0000, 32'h0, 32'h0002_0000, 32'h0);
      wait_until(t + 66);
      check("cap_done", int'(done), 1);
      t2 = cyc;
      push_line(t2, 32'h0005_0000, 32'h0005_0000, 32'h0001_0000, 0, 32'h0001_0000, 9);
      start_op(2'd3, 4'd9, 32'h0005_0000, 32'h0005_0000, 32'h0001_0000, 32'h0, 32'h0001_0000);
      check("done_restart_busy", int'(busy), 1);
      wait_until(t2 + 4);

      // Reset in cycle t+5 of a line: writes k=0..4 only, never a done.
      t = cyc;
      for (int k = 0; k < 5; k++) exp_q.push_back('{t + 1 + k, 12840 + 320 * k, 5});
      start_op(2'd0, 4'd5, 32'h0028_0000, 32'h0028_0000, 32'h0, 32'h0001_0000, 32'h000A_0000);
      wait_until(t + 5);
      rst_n = 1'b0;
      wait_until(t + 6);
      check("abort_we", int'(draw_we), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      rst_n = 1'b1;
      wait_until(t + 30);
      check("abort_idle_busy", int'(busy), 0);

      check("wr_queue_drained", exp_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
